// File: rtl/jpeg_image_buffer.sv
// jpeg_image_buffer: capture RAM for the JPEG encoder's compressed words.
// Latches the final size and flags overflow and out-of-order addresses.
module jpeg_image_buffer #(
    parameter int BUFFER_BYTES = 16384,
    parameter int AW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_in,
    input  logic [31:0]   data_in,
    input  logic [AW-1:0] address_in,
    input  logic          data_valid_in,
    input  logic          image_valid_in,
    input  logic [AW-1:0] rd_addr_in,
    input  logic          rd_en_in,
    output logic [7:0]    rd_data_out,
    output logic          rd_valid_out,
    output logic          busy_out,
    output logic          done_out,
    output logic [AW:0]   image_size_out,
    output logic          overflow_out,
    output logic          seq_error_out
);
    localparam int            WORDS     = BUFFER_BYTES / 4;
    localparam int            WIDX      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW:0]   LIMIT     = (AW+1)'(BUFFER_BYTES);
    localparam logic [AW-1:0] COUNT_MAX = {{(AW-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] byte_count_q, byte_count_d;
    logic [AW:0]   image_size_q, image_size_d;
    logic          overflow_q, overflow_d;
    logic          seq_error_q, seq_error_d;
    logic          iv_q, iv_d;

    logic          in_range;
    logic          iv_rise;
    logic          wr_en;
    logic [AW-1:0] count_inc;

    logic [31:0]   mem [WORDS];
    logic [31:0]   ram_rdata_q;
    logic          rd_hit;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_zero_q, rd_zero_d;
    logic [1:0]    rd_sel_q, rd_sel_d;

    assign in_range  = ({1'b0, address_in} < LIMIT);
    assign iv_rise   = image_valid_in & ~iv_q;
    assign count_inc = (byte_count_q == COUNT_MAX) ? COUNT_MAX
                                                   : byte_count_q + AW'(4);
    assign rd_hit    = rd_en_in & ({1'b0, rd_addr_in} < LIMIT);

    // Next-state, counters and sticky flags; restart overrides everything
    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        image_size_d = image_size_q;
        overflow_d   = overflow_q;
        seq_error_d  = seq_error_q;
        iv_d         = image_valid_in;
        wr_en        = 1'b0;
        if (start_in) begin
            state_d      = CAPTURE;
            byte_count_d = '0;
            image_size_d = '0;
            overflow_d   = 1'b0;
            seq_error_d  = 1'b0;
        end else if (state_q == CAPTURE) begin
            if (data_valid_in) begin
                wr_en        = in_range;
                byte_count_d = count_inc;
                if (!in_range)
                    overflow_d = 1'b1;
                if (address_in != byte_count_q)
                    seq_error_d = 1'b1;
            end
            if (iv_rise) begin
                state_d      = DONE;
                image_size_d = ({1'b0, byte_count_d} > LIMIT)
                             ? LIMIT : {1'b0, byte_count_d};
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_count_q <= '0;
            image_size_q <= '0;
            overflow_q   <= 1'b0;
            seq_error_q  <= 1'b0;
            iv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            image_size_q <= image_size_d;
            overflow_q   <= overflow_d;
            seq_error_q  <= seq_error_d;
            iv_q         <= iv_d;
        end
    end

    // Word RAM, read-first on a same-word collision
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[address_in[WIDX+1:2]] <= data_in;
        if (rd_hit)
            ram_rdata_q <= mem[rd_addr_in[WIDX+1:2]];
    end

    // Read-side qualifiers; byte lane and range are held between reads
    always_comb begin
        rd_valid_d = rd_en_in;
        rd_zero_d  = rd_zero_q;
        rd_sel_d   = rd_sel_q;
        if (rd_en_in) begin
            rd_zero_d = ~rd_hit;
            rd_sel_d  = rd_addr_in[1:0];
        end
    end

    // Read pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_sel_q   <= 2'b00;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    assign rd_data_out    = rd_zero_q ? 8'h00
                                      : ram_rdata_q[{rd_sel_q, 3'b000} +: 8];
    assign rd_valid_out   = rd_valid_q;
    assign busy_out       = (state_q == CAPTURE);
    assign done_out       = (state_q == DONE);
    assign image_size_out = image_size_q;
    assign overflow_out   = overflow_q;
    assign seq_error_out  = seq_error_q;

endmodule

// File: tb/tb_jpeg_image_buffer.sv
// tb_jpeg_image_buffer: random and directed captures against a byte-level
// model; read bytes flow through a scoreboard queue checked by a monitor.
module tb_jpeg_image_buffer;
    localparam int BB = 64;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_in;
    logic [31:0]   data_in;
    logic [AW-1:0] address_in;
    logic          data_valid_in;
    logic          image_valid_in;
    logic [AW-1:0] rd_addr_in;
    logic          rd_en_in;
    logic [7:0]    rd_data_out;
    logic          rd_valid_out;
    logic          busy_out;
    logic          done_out;
    logic [AW:0]   image_size_out;
    logic          overflow_out;
    logic          seq_error_out;

    always #5 clk = ~clk;

    jpeg_image_buffer #(.BUFFER_BYTES(BB), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start_in(start_in),
        .data_in(data_in),
        .address_in(address_in),
        .data_valid_in(data_valid_in),
        .image_valid_in(image_valid_in),
        .rd_addr_in(rd_addr_in),
        .rd_en_in(rd_en_in),
        .rd_data_out(rd_data_out),
        .rd_valid_out(rd_valid_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .image_size_out(image_size_out),
        .overflow_out(overflow_out),
        .seq_error_out(seq_error_out)
    );

    typedef struct {
        logic [7:0] val;
        bit         chk;
    } exp_t;

    exp_t       rdq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mmem [BB];
    bit         known [BB];
    bit         m_busy, m_done, m_ovf, m_seq, m_piv;
    int         m_cnt, m_size;
    logic [7:0] last_exp;
    bit         hold_ok;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_ovf = 0; m_seq = 0; m_piv = 0;
        m_cnt = 0; m_size = 0;
        for (int i = 0; i < BB; i++) known[i] = 0;
        last_exp = 8'h00;
        hold_ok = 1;
    endfunction

    // Monitor: pops one expectation per presented read byte
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (rd_valid_out) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    e = rdq.pop_front();
                    if (e.chk) begin
                        chk("rd_data", rd_data_out, e.val);
                        last_exp = e.val;
                        hold_ok = 1;
                    end else begin
                        hold_ok = 0;
                    end
                end
            end else if (hold_ok) begin
                chk("rd_hold", rd_data_out, last_exp);
            end
        end
    end

    task automatic step(input bit st, input bit dv, input logic [15:0] a,
                        input logic [31:0] d, input bit iv, input bit re,
                        input logic [15:0] ra);
        exp_t e;
        start_in = st; data_valid_in = dv; address_in = a; data_in = d;
        image_valid_in = iv; rd_en_in = re; rd_addr_in = ra;
        if (re) begin
            if (int'(ra) >= BB) begin
                e.val = 8'h00; e.chk = 1;
            end else begin
                e.val = mmem[ra]; e.chk = known[ra];
            end
            rdq.push_back(e);
        end
        if (st) begin
            m_busy = 1; m_done = 0; m_cnt = 0; m_size = 0;
            m_ovf = 0; m_seq = 0;
        end else if (m_busy) begin
            if (dv) begin
                if (int'(a) != m_cnt) m_seq = 1;
                if (int'(a) < BB) begin
                    for (int k = 0; k < 4; k++) begin
                        mmem[int'(a) + k] = d[8*k +: 8];
                        known[int'(a) + k] = 1;
                    end
                end else begin
                    m_ovf = 1;
                end
                m_cnt = (m_cnt + 4 > 65532) ? 65532 : m_cnt + 4;
            end
            if (iv && !m_piv) begin
                m_busy = 0; m_done = 1;
                m_size = (m_cnt < BB) ? m_cnt : BB;
            end
        end
        m_piv = iv;
        @(posedge clk);
        #1;
        chk("busy", busy_out, m_busy);
        chk("done", done_out, m_done);
        chk("overflow", overflow_out, m_ovf);
        chk("seq_error", seq_error_out, m_seq);
        if (m_done) chk("image_size", image_size_out, m_size);
    endtask

    task automatic idle(input bit iv);
        step(0, 0, 16'h0, 32'h0, iv, 0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] ra, input bit iv);
        step(0, 0, 16'h0, 32'h0, iv, 1, ra);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input bit iv);
        step(0, 1, a, d, iv, 0, 16'h0);
    endtask

    task automatic start(input bit iv);
        step(1, 0, 16'h0, 32'h0, iv, 0, 16'h0);
    endtask

    task automatic do_reset();
        start_in = 0; data_valid_in = 0; rd_en_in = 0; image_valid_in = 0;
        @(negedge clk);
        #1 reset = 1;
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_size", image_size_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_seq", seq_error_out, 0);
        chk("rst_rd_valid", rd_valid_out, 0);
        chk("rst_rd_data", rd_data_out, 0);
        @(posedge clk);
        #1 reset = 0;
        rdq.delete();
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] addr;
        logic [15:0] a;
        int          n;
        reset = 1; start_in = 0; data_in = 0; address_in = 0;
        data_valid_in = 0; image_valid_in = 0; rd_addr_in = 0; rd_en_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", busy_out, 0);
        chk("init_done", done_out, 0);
        chk("init_size", image_size_out, 0);
        chk("init_ovf", overflow_out, 0);
        chk("init_seq", seq_error_out, 0);
        chk("init_rd_valid", rd_valid_out, 0);
        chk("init_rd_data", rd_data_out, 0);
        reset = 0;
        idle(0);

        // normal capture
        start(0);
        for (int i = 0; i < 5; i++) wr(16'(4*i), 32'h44332211 + i, 0);
        idle(1);
        for (int i = 0; i < 4; i++) rd(16'(i), 1);
        rd(16'd16, 1);
        idle(1);

        // stale image_valid across start
        start(1);
        wr(16'd0, 32'hA1A2A3A4, 1);
        wr(16'd4, 32'hB1B2B3B4, 1);
        idle(1);
        idle(0);
        idle(1);
        idle(0);

        // sequence error
        start(0);
        wr(16'd0, 32'h01020304, 0);
        wr(16'd4, 32'h05060708, 0);
        wr(16'd12, 32'hC0C1C2C3, 0);
        idle(1);
        for (int i = 12; i < 16; i++) rd(16'(i), 1);
        idle(0);

        // start with data_valid; last word with image_valid rise
        step(1, 1, 16'd0, 32'hDEADBEEF, 0, 0, 16'h0);
        wr(16'd0, 32'h10203040, 0);
        wr(16'd4, 32'h50607080, 0);
        wr(16'd8, 32'h90A0B0C0, 1);
        idle(1);
        idle(0);

        // overflow
        start(0);
        for (int i = 0; i < 20; i++) wr(16'(4*i), $urandom, 0);
        idle(1);
        for (int i = 0; i <= 64; i++) rd(16'(i), 1);
        rd(16'd100, 1);
        rd(16'hFFFF, 1);
        idle(0);

        // read-during-write to the same word
        start(0);
        wr(16'd0, 32'h11223344, 0);
        step(0, 1, 16'd4, 32'h55667788, 0, 1, 16'd0);
        step(0, 1, 16'd0, 32'hCAFEF00D, 0, 1, 16'd1);
        step(0, 0, 16'd0, 32'h0, 0, 1, 16'd1);
        rd(16'd5, 0);
        idle(0);

        // reset mid-capture, then stimulus ignored in IDLE
        start(0);
        wr(16'd0, 32'h12345678, 0);
        wr(16'd4, 32'h9ABCDEF0, 0);
        do_reset();
        step(0, 1, 16'd8, 32'h1, 0, 0, 16'h0);
        step(0, 1, 16'd12, 32'h2, 1, 0, 16'h0);
        idle(1);
        idle(0);

        // randomized captures with concurrent reads
        for (int r = 0; r < 8; r++) begin
            start(0);
            n = $urandom_range(1, 24);
            addr = 0;
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    step(0, 0, 16'h0, 32'h0, 0, 1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 127)));
                end else begin
                    a = ($urandom_range(0, 9) == 0)
                      ? addr + 16'(4 * $urandom_range(1, 3)) : addr;
                    step(0, 1, a, $urandom,
                         (j == n - 1) && ($urandom_range(0, 1) == 1),
                         1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 127)));
                    addr = a + 16'd4;
                end
            end
            idle(1);
            for (int j = 0; j < 10; j++) rd(16'($urandom_range(0, 80)), 1);
            idle(0);
        end

        // byte counter saturation at the top of the address space
        start(0);
        for (int i = 0; i < 16384; i++) wr(16'(4*i), 32'(i), 0);
        wr(16'hFFFC, 32'h0, 0);
        idle(1);
        idle(0);

        repeat (3) idle(0);
        chk("rdq_empty", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
